// File: rtl/tanimoto_pkg.sv
// Shared state encoding, Q0.16 ratio constants and default sizing for the
// Tanimoto job sequencer and the tanimoto_top datapath.
package tanimoto_pkg;

  localparam int unsigned RATIO_FRAC_BITS = 16;
  localparam logic [RATIO_FRAC_BITS-1:0] RATIO_ONE = 16'hFFFF;

  localparam int unsigned DEF_BUS_WIDTH     = 512;
  localparam int unsigned DEF_VECTOR_WIDTH  = 920;
  localparam int unsigned DEF_SUB_VECTOR_NO = 2;
  localparam int unsigned DEF_REF_VEC_NO    = 32;
  localparam int unsigned DEF_JOB_CNT_WIDTH = 16;
  localparam int unsigned DEF_DRAIN_CYCLES  = 64;

  localparam int unsigned STATE_WIDTH = 3;

  typedef enum logic [STATE_WIDTH-1:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD_THR   = 3'd1,
    ST_STREAM_REF = 3'd2,
    ST_STREAM_CMP = 3'd3,
    ST_DRAIN      = 3'd4,
    ST_DONE       = 3'd5
  } job_state_e;

  // One spare bit so CmpVecCnt * SUB_VECTOR_NO can never wrap.
  function automatic int unsigned beat_cnt_width(input int unsigned job_cnt_w,
                                                 input int unsigned sub_vec_no);
    return job_cnt_w + int'($clog2(sub_vec_no)) + 1;
  endfunction

  localparam int unsigned DEF_CNT_WIDTH      = $clog2(DEF_VECTOR_WIDTH);
  localparam int unsigned DEF_BEAT_CNT_WIDTH = beat_cnt_width(DEF_JOB_CNT_WIDTH, DEF_SUB_VECTOR_NO);

endpackage

// File: rtl/threshold_table_gen.sv
// Threshold BRAM fill: writes ceil(a*R/2^16) for a = 0..VECTOR_WIDTH, one per
// cycle, using a running accumulator instead of a multiplier.
module threshold_table_gen
  import tanimoto_pkg::*;
#(
  parameter int unsigned VECTOR_WIDTH = DEF_VECTOR_WIDTH,
  parameter int unsigned CNT_WIDTH    = $clog2(VECTOR_WIDTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic                       run_i,
  input  logic [RATIO_FRAC_BITS-1:0] ratio_i,
  output logic [CNT_WIDTH-1:0]       addr_o,
  output logic [CNT_WIDTH:0]         din_o,
  output logic                       wr_o,
  output logic                       last_o
);

  localparam int unsigned ACC_WIDTH = CNT_WIDTH + 17;
  localparam int unsigned DIN_WIDTH = CNT_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] LAST_ADDR = CNT_WIDTH'(VECTOR_WIDTH);

  logic [RATIO_FRAC_BITS-1:0] ratio_q;
  logic [ACC_WIDTH-1:0]       acc_q, acc_d;
  logic [CNT_WIDTH-1:0]       addr_q, addr_d;
  logic [DIN_WIDTH-1:0]       din_q, din_d;
  logic                       wr_q;
  logic                       last_q;

  // Next table entry; adding RATIO_ONE before the shift turns floor into ceil.
  always_comb begin
    acc_d  = acc_q + ACC_WIDTH'(ratio_q);
    addr_d = addr_q + CNT_WIDTH'(1);
    din_d  = DIN_WIDTH'((acc_d + ACC_WIDTH'(RATIO_ONE)) >> RATIO_FRAC_BITS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ratio_q <= '0;
      acc_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      wr_q    <= 1'b0;
      last_q  <= 1'b0;
    end else if (start_i) begin
      // Address 0 is always written with 0 in the cycle after start.
      ratio_q <= ratio_i;
      acc_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      wr_q    <= 1'b1;
      last_q  <= (LAST_ADDR == '0);
    end else if (run_i && wr_q) begin
      if (last_q) begin
        acc_q  <= '0;
        addr_q <= '0;
        din_q  <= '0;
        wr_q   <= 1'b0;
        last_q <= 1'b0;
      end else begin
        acc_q  <= acc_d;
        addr_q <= addr_d;
        din_q  <= din_d;
        last_q <= (addr_d == LAST_ADDR);
      end
    end
  end

  assign addr_o = addr_q;
  assign din_o  = din_q;
  assign wr_o   = wr_q;
  assign last_o = last_q;

endmodule

// File: rtl/tanimoto_job_ctrl.sv
// Job sequencer in front of tanimoto_top: threshold fill, reference and
// compare stream gating with beat counting, drain wait and done pulse.
module tanimoto_job_ctrl
  import tanimoto_pkg::*;
#(
  parameter int unsigned BUS_WIDTH     = DEF_BUS_WIDTH,
  parameter int unsigned VECTOR_WIDTH  = DEF_VECTOR_WIDTH,
  parameter int unsigned SUB_VECTOR_NO = DEF_SUB_VECTOR_NO,
  parameter int unsigned REF_VEC_NO    = DEF_REF_VEC_NO,
  parameter int unsigned CNT_WIDTH     = $clog2(VECTOR_WIDTH),
  parameter int unsigned JOB_CNT_WIDTH = DEF_JOB_CNT_WIDTH,
  parameter int unsigned DRAIN_CYCLES  = DEF_DRAIN_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_Start,
  input  logic [RATIO_FRAC_BITS-1:0] i_Ratio,
  input  logic [JOB_CNT_WIDTH-1:0]   i_CmpVecCnt,
  input  logic                       i_Valid,
  input  logic                       i_DutRead,
  input  logic                       i_IDPair_Ready,
  output logic                       o_DutValid,
  output logic                       o_FifoRead,
  output logic [CNT_WIDTH-1:0]       o_BRAM_Addr,
  output logic [CNT_WIDTH:0]         o_BRAM_Din,
  output logic                       o_BRAM_En,
  output logic                       o_BRAM_WrEn,
  output logic                       o_Busy,
  output logic                       o_Done,
  output logic [STATE_WIDTH-1:0]     o_State
);

  localparam int unsigned BEAT_W = beat_cnt_width(JOB_CNT_WIDTH, SUB_VECTOR_NO);
  localparam int unsigned IDLE_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [BEAT_W-1:0] REF_LAST   = BEAT_W'(REF_VEC_NO * SUB_VECTOR_NO - 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(DRAIN_CYCLES);
  localparam int unsigned VEC_BEAT_BITS = BUS_WIDTH * SUB_VECTOR_NO;

  // Data is forwarded untouched; a vector that does not fit its beats leaves a marker scope.
  if (VEC_BEAT_BITS < VECTOR_WIDTH) begin : g_vector_exceeds_beats
  end

  job_state_e          state_q, state_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [BEAT_W-1:0]   cmp_beats_q, cmp_beats_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic                busy_q, done_q;

  logic                gate_open_c, beat_c, start_c;
  logic                gen_last, gen_wr;

  assign gate_open_c = (state_q == ST_STREAM_REF) || (state_q == ST_STREAM_CMP);
  assign beat_c      = i_Valid & i_DutRead & gate_open_c;
  assign start_c     = i_Start && (state_q == ST_IDLE);

  threshold_table_gen #(
    .VECTOR_WIDTH (VECTOR_WIDTH),
    .CNT_WIDTH    (CNT_WIDTH)
  ) u_thr_gen (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_c),
    .run_i   (state_q == ST_LOAD_THR),
    .ratio_i (i_Ratio),
    .addr_o  (o_BRAM_Addr),
    .din_o   (o_BRAM_Din),
    .wr_o    (gen_wr),
    .last_o  (gen_last)
  );

  // Next-state and counter logic.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    cmp_beats_d = cmp_beats_q;
    idle_cnt_d  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_Start) begin
          cmp_beats_d = BEAT_W'(i_CmpVecCnt) * BEAT_W'(SUB_VECTOR_NO);
          beat_cnt_d  = '0;
          state_d     = ST_LOAD_THR;
        end
      end
      ST_LOAD_THR: begin
        if (gen_last) state_d = ST_STREAM_REF;
      end
      ST_STREAM_REF: begin
        if (beat_c) begin
          if (beat_cnt_q == REF_LAST) begin
            beat_cnt_d = '0;
            state_d    = (cmp_beats_q == '0) ? ST_DRAIN : ST_STREAM_CMP;
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
        end
      end
      ST_STREAM_CMP: begin
        if (beat_c) begin
          if (beat_cnt_q == cmp_beats_q - BEAT_W'(1)) begin
            beat_cnt_d = '0;
            state_d    = ST_DRAIN;
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        // Any ID-pair activity restarts the idle window.
        if (!i_IDPair_Ready) begin
          idle_cnt_d = idle_cnt_q + IDLE_W'(1);
          if (idle_cnt_d == IDLE_LIMIT) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      beat_cnt_q  <= '0;
      cmp_beats_q <= '0;
      idle_cnt_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      cmp_beats_q <= cmp_beats_d;
      idle_cnt_q  <= idle_cnt_d;
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= (state_d == ST_DONE);
    end
  end

  assign o_DutValid  = i_Valid & gate_open_c;
  assign o_FifoRead  = i_DutRead & gate_open_c;
  assign o_BRAM_En   = gen_wr;
  assign o_BRAM_WrEn = gen_wr;
  assign o_Busy      = busy_q;
  assign o_Done      = done_q;
  assign o_State     = state_q;

endmodule

// File: tb/tb_tanimoto_job_ctrl.sv
// Self-checking bench for tanimoto_job_ctrl: table of jobs with a threshold
// scoreboard, plus hand-written reset-abort sequences.
module tb_tanimoto_job_ctrl;

  localparam int VW = 920;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_Start = 1'b0;
  logic [15:0] i_Ratio = '0;
  logic [15:0] i_CmpVecCnt = '0;
  logic        i_Valid = 1'b0;
  logic        i_DutRead = 1'b0;
  logic        i_IDPair_Ready = 1'b0;
  logic        o_DutValid, o_FifoRead, o_BRAM_En, o_BRAM_WrEn, o_Busy, o_Done;
  logic [9:0]  o_BRAM_Addr;
  logic [10:0] o_BRAM_Din;
  logic [2:0]  o_State;

  always #5 clk = ~clk;

  tanimoto_job_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .i_Start        (i_Start),
    .i_Ratio        (i_Ratio),
    .i_CmpVecCnt    (i_CmpVecCnt),
    .i_Valid        (i_Valid),
    .i_DutRead      (i_DutRead),
    .i_IDPair_Ready (i_IDPair_Ready),
    .o_DutValid     (o_DutValid),
    .o_FifoRead     (o_FifoRead),
    .o_BRAM_Addr    (o_BRAM_Addr),
    .o_BRAM_Din     (o_BRAM_Din),
    .o_BRAM_En      (o_BRAM_En),
    .o_BRAM_WrEn    (o_BRAM_WrEn),
    .o_Busy         (o_Busy),
    .o_Done         (o_Done),
    .o_State        (o_State)
  );

  typedef struct {
    logic [15:0] ratio;
    int          cmp;
    int          pulse_a;
    int          pulse_b;
    bit          rand_read;
    bit          start_in_ref;
  } job_t;

  typedef struct {
    logic [15:0] ratio;
    int          addr;
    int          din;
  } spot_t;

  typedef struct {
    int addr;
    int din;
  } thr_t;

  int    checks = 0;
  int    errors = 0;
  thr_t  thr_q[$];
  int    din_seen[0:VW];
  job_t  jobs[5];
  spot_t spots[10];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_job(input job_t j);
    int   cyc = 0;
    int   wr_cnt = 0, first_wr = -1, first_ref = -1, drain_start = -1;
    int   ref_beats = 0, cmp_beats = 0, done_cyc = -1, done_cnt = 0;
    int   gate_err = 0, busy_err = 0, idx_ref = 0, st = 0, last_pulse, exp_done;
    bit   saw_cmp = 0, finished = 0, open;
    thr_t t;

    thr_q.delete();
    for (int a = 0; a <= VW; a++) begin
      t.addr = a;
      t.din  = int'((longint'(a) * longint'(j.ratio) + 64'd65535) >> 16);
      thr_q.push_back(t);
    end

    @(negedge clk);
    i_Start = 1'b1; i_Ratio = j.ratio; i_CmpVecCnt = 16'(j.cmp);
    i_Valid = 1'b1; i_DutRead = 1'b1; i_IDPair_Ready = 1'b0;
    #1;
    chk("start_cycle_state", o_State, 0);

    while (!finished && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      st = int'(o_State);
      i_Start     = 1'b0;
      i_Ratio     = 16'($urandom);
      i_CmpVecCnt = 16'($urandom);
      i_DutRead   = j.rand_read ? 1'($urandom_range(0, 1)) : 1'b1;
      if (st == 2) begin
        if (j.start_in_ref && idx_ref == 5) i_Start = 1'b1;
        idx_ref++;
      end
      if (st == 4 && drain_start < 0) drain_start = cyc;
      if (st == 4)
        i_IDPair_Ready = ((cyc - drain_start) == j.pulse_a) || ((cyc - drain_start) == j.pulse_b);
      else
        i_IDPair_Ready = 1'($urandom_range(0, 1));
      #1;

      if (o_BRAM_WrEn) begin
        wr_cnt++;
        if (first_wr < 0) first_wr = cyc;
        if (thr_q.size() == 0) begin
          chk("thr_extra_write", 1, 0);
        end else begin
          t = thr_q.pop_front();
          chk("thr_addr", o_BRAM_Addr, t.addr);
          chk("thr_din", o_BRAM_Din, t.din);
          din_seen[t.addr] = int'(o_BRAM_Din);
        end
      end
      open = (st == 2) || (st == 3);
      if (o_DutValid !== (i_Valid & open) || o_FifoRead !== (i_DutRead & open)) gate_err++;
      if (o_BRAM_En !== o_BRAM_WrEn || (o_BRAM_WrEn && st != 1)) gate_err++;
      if (o_Busy !== (st != 0)) busy_err++;
      if (o_DutValid && o_FifoRead) begin
        if (st == 2) ref_beats++;
        else if (st == 3) cmp_beats++;
      end
      if (st == 2 && first_ref < 0) first_ref = cyc;
      if (st == 3) saw_cmp = 1'b1;

      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        chk("post_done_busy", o_Busy, 0);
        chk("post_done_state", o_State, 0);
        chk("post_done_pulse", o_Done, 0);
        finished = 1'b1;
      end else if (o_Done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          chk("done_state", o_State, 5);
        end
      end
    end
    i_IDPair_Ready = 1'b0;

    if (!finished) chk("job_timeout", 0, 1);
    chk("wr_count", wr_cnt, VW + 1);
    chk("first_wr_cycle", first_wr, 1);
    chk("thr_left", thr_q.size(), 0);
    chk("ref_open_cycle", first_ref, VW + 2);
    chk("ref_beats", ref_beats, 64);
    chk("cmp_beats", cmp_beats, 2 * j.cmp);
    chk("cmp_state_seen", saw_cmp, (j.cmp != 0));
    chk("gate_errors", gate_err, 0);
    chk("busy_errors", busy_err, 0);
    chk("done_count", done_cnt, 1);
    last_pulse = (j.pulse_a > j.pulse_b) ? j.pulse_a : j.pulse_b;
    exp_done = (last_pulse < 0) ? drain_start + 64 : drain_start + last_pulse + 65;
    chk("done_cycle", done_cyc, exp_done);
    for (int s = 0; s < 10; s++)
      if (spots[s].ratio == j.ratio) chk("spot_din", din_seen[spots[s].addr], spots[s].din);
  endtask

  initial begin
    int n;
    int cnt;

    jobs[0] = '{16'h8000, 128, 10, 50, 1'b1, 1'b0};
    jobs[1] = '{16'hFFFF,   0, -1, -1, 1'b0, 1'b1};
    jobs[2] = '{16'h0000,   3,  0, -1, 1'b1, 1'b0};
    jobs[3] = '{16'h4000,   1, -1, -1, 1'b1, 1'b1};
    jobs[4] = '{16'h0001,   2, 63, -1, 1'b0, 1'b0};

    spots[0] = '{16'h8000,   0,   0};
    spots[1] = '{16'h8000,   3,   2};
    spots[2] = '{16'h8000, 920, 460};
    spots[3] = '{16'h8000,   1,   1};
    spots[4] = '{16'hFFFF,   1,   1};
    spots[5] = '{16'hFFFF, 920, 920};
    spots[6] = '{16'h0000, 500,   0};
    spots[7] = '{16'h0000, 920,   0};
    spots[8] = '{16'h4000,   5,   2};
    spots[9] = '{16'h0001, 920,   1};

    // Reset values with handshake inputs active.
    rst = 1'b1; i_Valid = 1'b1; i_DutRead = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_state", o_State, 0);
    chk("rst_busy", o_Busy, 0);
    chk("rst_done", o_Done, 0);
    chk("rst_wren", o_BRAM_WrEn, 0);
    chk("rst_en", o_BRAM_En, 0);
    chk("rst_addr", o_BRAM_Addr, 0);
    chk("rst_din", o_BRAM_Din, 0);
    chk("rst_dutvalid", o_DutValid, 0);
    chk("rst_fiforead", o_FifoRead, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 5; k++) run_job(jobs[k]);

    // Abort in STREAM_CMP.
    @(negedge clk);
    i_Start = 1'b1; i_Ratio = 16'h1234; i_CmpVecCnt = 16'd4; i_Valid = 1'b1; i_DutRead = 1'b1;
    n = 0; cnt = 0;
    while (cnt < 3 && n < 3000) begin
      @(negedge clk);
      i_Start = 1'b0;
      n++;
      #1;
      if (o_State == 3'd3) cnt++;
    end
    chk("abort_reached_cmp", o_State, 3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_cmp_state", o_State, 0);
    chk("abort_cmp_busy", o_Busy, 0);
    chk("abort_cmp_dutvalid", o_DutValid, 0);
    chk("abort_cmp_fiforead", o_FifoRead, 0);
    cnt = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      #1;
      if (o_Done || o_FifoRead || o_State != 3'd0) cnt++;
    end
    chk("abort_cmp_quiet", cnt, 0);

    // Abort in LOAD_THR.
    @(negedge clk);
    i_Start = 1'b1; i_Ratio = 16'hFFFF; i_CmpVecCnt = 16'd1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      i_Start = 1'b0;
    end
    #1;
    chk("load_wren_mid", o_BRAM_WrEn, 1);
    chk("load_addr_mid", o_BRAM_Addr, 299);
    chk("load_din_mid", o_BRAM_Din, 299);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_load_state", o_State, 0);
    chk("abort_load_wren", o_BRAM_WrEn, 0);
    chk("abort_load_en", o_BRAM_En, 0);
    chk("abort_load_addr", o_BRAM_Addr, 0);
    chk("abort_load_din", o_BRAM_Din, 0);

    // A clean job after the aborts.
    run_job(jobs[3]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
